// File: rtl/alu_pkg.sv
// Shared encodings for the ALU shift path: shift modes and sequencer states.
package alu_pkg;

   localparam int SHR_W = 32;

   typedef enum logic [1:0] {
      SHR_LOGICAL = 2'b00,
      SHR_ARITH   = 2'b01,
      SHR_ROTATE  = 2'b10
   } shr_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } shr_state_e;

endpackage

// File: rtl/shift_right.sv
// One-bit combinational right shift: the vacated MSB is filled from new_msb and
// the bit falling off the bottom is reported on shifted_lsb.
module shift_right
   import alu_pkg::*;
(
   input  logic [SHR_W-1:0] A,
   input  logic             new_msb,
   output logic [SHR_W-1:0] R,
   output logic             shifted_lsb
);

   assign R           = {new_msb, A[SHR_W-1:1]};
   assign shifted_lsb = A[0];

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle shift sequencer: drives the 1-bit shift_right cell once per clock
// to perform 0-31 bit logical, arithmetic or rotate right shifts.
module shift_right_seq
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SHR_W-1:0] A,
   input  logic [4:0]       amt,
   input  logic [1:0]       mode,
   output logic [SHR_W-1:0] R,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   shr_state_e       r_state;
   shr_state_e       w_state_next;
   logic [SHR_W-1:0] r_result;
   logic             r_carry;
   logic [4:0]       r_cnt;
   logic [1:0]       r_mode;
   logic             r_sign;

   logic             w_new_msb;
   logic [SHR_W-1:0] w_shifted;
   logic             w_shifted_lsb;

   shift_right u_shift_right (
      .A           (r_result),
      .new_msb     (w_new_msb),
      .R           (w_shifted),
      .shifted_lsb (w_shifted_lsb)
   );

   // Reserved mode 11 falls through to the logical fill.
   always_comb begin
      w_new_msb = 1'b0;
      case (r_mode)
         SHR_ARITH:  w_new_msb = r_sign;
         SHR_ROTATE: w_new_msb = r_result[0];
         default:    w_new_msb = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = (amt != 5'd0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (r_cnt == 5'd1) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // SHIFT is only entered with r_cnt >= 1, so the decrement never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= 5'd0;
         r_mode   <= 2'b00;
         r_sign   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_result <= A;
                  r_cnt    <= amt;
                  r_mode   <= mode;
                  r_sign   <= A[SHR_W-1];
                  r_carry  <= 1'b0;
               end
            end
            SHIFT: begin
               r_result <= w_shifted;
               r_carry  <= w_shifted_lsb;
               r_cnt    <= r_cnt - 5'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign R     = r_result;
   assign carry = r_carry;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed and random shifts compared
// against an arithmetic reference model, plus ignored-start and reset-abort cases.
module tb_shift_right_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] A;
   logic [4:0]  amt;
   logic [1:0]  mode;
   logic [31:0] R;
   logic        carry;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   shift_right_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .amt   (amt),
      .mode  (mode),
      .R     (R),
      .carry (carry),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Reference: a right shift by n of the whole word; carry is the last bit to
   // leave, which is original bit n-1 for every mode.
   function automatic void model(input logic [31:0] a, input int n, input logic [1:0] m,
                                 output logic [31:0] r, output logic c);
      logic [63:0] w;
      c = (n == 0) ? 1'b0 : a[n-1];
      case (m)
         2'b01:   r = $signed(a) >>> n;
         2'b10:   begin w = {a, a}; r = w[n +: 32]; end
         default: r = a >> n;
      endcase
   endfunction

   // inj >= 0: pulse start with junk operands so it is sampled at edge E+inj+1.
   task automatic run_op(input logic [31:0] a, input logic [4:0] n, input logic [1:0] m,
                         input int inj);
      logic [31:0] exp_r;
      logic        exp_c;
      int          k;
      model(a, int'(n), m, exp_r, exp_c);
      @(negedge clk);
      A = a; amt = n; mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0; A = $urandom; amt = 5'($urandom); mode = 2'($urandom);
      k = 0;
      while (!done && k < 40) begin
         chk("busy_during", {31'd0, busy}, 32'd1);
         if (k == inj) begin
            start = 1'b1;
            A     = $urandom;
            amt   = 5'($urandom_range(1, 31));
         end
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      chk("done_cycle", k, {27'd0, n});
      chk("result", R, exp_r);
      chk("carry", {31'd0, carry}, {31'd0, exp_c});
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      $display("op A=%08h amt=%0d mode=%0d -> R=%08h carry=%0b after %0d cycles",
               a, n, m, R, carry, k);
      @(negedge clk);
      chk("done_pulse_end", {31'd0, done}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("result_held", R, exp_r);
      chk("carry_held", {31'd0, carry}, {31'd0, exp_c});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; A = '0; amt = '0; mode = '0;
      repeat (3) @(negedge clk);
      chk("rst_R", R, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      run_op(32'hFFFF0000, 5'd4,  2'b00, -1);
      run_op(32'h80000001, 5'd1,  2'b01, -1);
      run_op(32'h00000001, 5'd31, 2'b10, -1);
      run_op(32'h1FFFFFFF, 5'd0,  2'b10, -1);
      run_op(32'hF0000000, 5'd31, 2'b01, -1);
      run_op(32'h80000000, 5'd31, 2'b11, -1);

      // Start pulsed while busy must be ignored.
      run_op(32'hA5A5F00F, 5'd8, 2'b10, 1);
      run_op(32'h8001_2345, 5'd3, 2'b01, 2);

      // Reset asserted before edge E+3 of an 8-step shift aborts it.
      @(negedge clk);
      A = 32'hDEADBEEF; amt = 5'd8; mode = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_R", R, 32'd0);
      chk("abort_carry", {31'd0, carry}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      $display("reset abort: R=%08h carry=%0b busy=%0b done=%0b", R, carry, busy, done);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("no_done_after_abort", {31'd0, done}, 32'd0);
      end
      run_op(32'h12345678, 5'd5, 2'b00, -1);

      for (int i = 0; i < 25; i++) begin
         run_op($urandom, 5'($urandom), 2'($urandom), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
